// File: rtl/hazard_control_if.sv
// rtl/hazard_control_if.sv - decode/execute sequencing bus between pipeline and hazard controller
interface hazard_control_if #(
  parameter int CNT_W = 16
);
  // decode-stage instruction description
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             id_writes_rd;
  logic             id_is_load;
  // execute-stage branch resolution
  logic             ex_taken;
  // sequencing controls back to the pipeline
  logic             stall;
  logic             flush;
  logic [1:0]       fwd_rs1;
  logic [1:0]       fwd_rs2;
  logic             ex_busy;
  logic [CNT_W-1:0] bubble_count;

  // pipeline side: describes the decode instruction, consumes controls
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd,
    output id_uses_rs1, id_uses_rs2, id_writes_rd, id_is_load,
    output ex_taken,
    input  stall, flush, fwd_rs1, fwd_rs2, ex_busy, bubble_count
  );

  // controller side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd,
    input  id_uses_rs1, id_uses_rs2, id_writes_rd, id_is_load,
    input  ex_taken,
    output stall, flush, fwd_rs1, fwd_rs2, ex_busy, bubble_count
  );
endinterface

// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - scoreboard, forwarding, load-use stall and branch flush for the 3-stage core
module hazard_control #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            reset,
  hazard_control_if.slave bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [1:0] SEL_RF     = 2'b00;
  localparam logic [1:0] SEL_EX     = 2'b01;
  localparam logic [1:0] SEL_WB     = 2'b10;

  state_t           state;
  // flush cycles still owed after the current one
  logic [2:0]       fcnt;

  // execute-slot shadow
  logic             ex_valid;
  logic             ex_writes;
  logic             ex_is_load;
  logic [4:0]       ex_rd;
  // write-slot shadow
  logic             wb_valid;
  logic             wb_writes;
  logic [4:0]       wb_rd;

  logic [CNT_W-1:0] bubble_q;

  logic             ex_m1;
  logic             ex_m2;
  logic             wb_m1;
  logic             wb_m2;
  logic             take;
  logic             flush_c;
  logic             load_hz;
  logic             stall_c;
  logic [1:0]       fwd1_c;
  logic [1:0]       fwd2_c;

  // x0 is hard-wired zero, so it never matches an in-flight producer
  assign ex_m1 = ex_valid & ex_writes & (ex_rd == bus.id_rs1) & (bus.id_rs1 != 5'd0);
  assign ex_m2 = ex_valid & ex_writes & (ex_rd == bus.id_rs2) & (bus.id_rs2 != 5'd0);
  assign wb_m1 = wb_valid & wb_writes & (wb_rd == bus.id_rs1) & (bus.id_rs1 != 5'd0);
  assign wb_m2 = wb_valid & wb_writes & (wb_rd == bus.id_rs2) & (bus.id_rs2 != 5'd0);

  // a bubble in execute cannot redirect fetch
  assign take    = bus.ex_taken & ex_valid;
  assign flush_c = (state == FLUSH) | take;

  // load data is not ready until the write stage, so a dependent reader waits one cycle
  assign load_hz = bus.id_valid & ex_is_load &
                   ((bus.id_uses_rs1 & ex_m1) | (bus.id_uses_rs2 & ex_m2));
  // a flush discards the stalled instruction anyway, so flush wins
  assign stall_c = load_hz & (state == RUN) & ~flush_c;

  // forwarding selects: execute result beats write result; loads cannot forward from execute
  always_comb begin
    fwd1_c = SEL_RF;
    fwd2_c = SEL_RF;
    if (!flush_c) begin
      if (bus.id_uses_rs1 & ex_m1 & ~ex_is_load) begin
        fwd1_c = SEL_EX;
      end else if (bus.id_uses_rs1 & wb_m1) begin
        fwd1_c = SEL_WB;
      end
      if (bus.id_uses_rs2 & ex_m2 & ~ex_is_load) begin
        fwd2_c = SEL_EX;
      end else if (bus.id_uses_rs2 & wb_m2) begin
        fwd2_c = SEL_WB;
      end
    end
  end

  // scoreboard advance: write takes execute, execute takes decode or a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_writes  <= 1'b0;
      ex_is_load <= 1'b0;
      ex_rd      <= 5'd0;
      wb_valid   <= 1'b0;
      wb_writes  <= 1'b0;
      wb_rd      <= 5'd0;
    end else begin
      wb_valid   <= ex_valid;
      wb_writes  <= ex_writes;
      wb_rd      <= ex_rd;
      ex_valid   <= bus.id_valid & ~stall_c & ~flush_c;
      ex_writes  <= bus.id_writes_rd;
      ex_is_load <= bus.id_is_load;
      ex_rd      <= bus.id_rd;
    end
  end

  // branch flush sequencer: the taken cycle is the first flush cycle, FLUSH covers the rest
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      fcnt  <= 3'd0;
    end else begin
      case (state)
        RUN: begin
          if (take && (FLUSH_CYCLES > 1)) begin
            state <= FLUSH;
            fcnt  <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (take && (FLUSH_CYCLES > 1)) begin
            fcnt <= FLUSH_LOAD;
          end else if (fcnt <= 3'd1) begin
            state <= RUN;
            fcnt  <= 3'd0;
          end else begin
            fcnt <= fcnt - 3'd1;
          end
        end
        default: begin
          state <= RUN;
          fcnt  <= 3'd0;
        end
      endcase
    end
  end

  // saturating bubble counter for performance debug
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_q <= '0;
    end else if ((stall_c | flush_c) && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_q <= bubble_q + 1'b1;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.flush        = flush_c;
  assign bus.fwd_rs1      = fwd1_c;
  assign bus.fwd_rs2      = fwd2_c;
  assign bus.ex_busy      = ex_valid;
  assign bus.bubble_count = bubble_q;

endmodule
